// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through receive FIFO between the UART RX deserialiser and APB read data.
// Define RX_FIFO_OVF_CNT_EN to add the sticky overflow flag, overflow counter and ovf_clr input.
module rx_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [ADDR_W:0]       level,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef RX_FIFO_OVF_CNT_EN
    ,
    input  logic                  ovf_clr,
    output logic                  ovf,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AF_L = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_L = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       level_q, level_d;
    logic                  full, empty;
    logic                  wr_fire, rd_fire;
    logic                  clear;

    // Handshake: a word moves on a rising edge where valid and ready are both 1.
    // ready_in depends only on full, so a full FIFO refuses a write even if a
    // read happens in the same cycle; valid_out/data_o never depend on ready_out.
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign ready_in  = !full;
    assign valid_out = !empty;
    assign data_o    = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign wr_fire = valid_in && !full;
    assign rd_fire = valid_out && ready_out;
    assign clear   = !rstn || flush;

    assign level        = level_q;
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is never cleared; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (!clear && wr_fire) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
        end
    end

`ifdef RX_FIFO_OVF_CNT_EN
    logic       ovf_q, ovf_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = 8'd0;
        end else if (valid_in && full) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_rx_fifo_fwft.sv
// Directed bench for rx_fifo_fwft (default parameters); a queue holds the words expected at the head.
module tb_rx_fifo_fwft;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic [DW-1:0] data_i;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_o;
    logic          valid_out;
    logic          ready_out;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;
`ifdef RX_FIFO_OVF_CNT_EN
    logic          ovf_clr;
    logic          ovf;
    logic [7:0]    ovf_cnt;
`endif

    logic [DW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;

    rx_fifo_fwft #(
        .DATA_WIDTH(DW),
        .ADDR_W    (AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .data_i      (data_i),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_o      (data_o),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .level       (level),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`ifdef RX_FIFO_OVF_CNT_EN
        ,
        .ovf_clr     (ovf_clr),
        .ovf         (ovf),
        .ovf_cnt     (ovf_cnt)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status outputs as the model predicts them from the expected-queue occupancy.
    task automatic chk_status(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(n != 0));
        chk({tag, ".ready_in"}, 32'(ready_in), 32'(n < DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: head data is checked before the edge, status after it.
    task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] d, input logic rd);
        bit will_wr, will_rd;
        valid_in  = wr;
        data_i    = d;
        ready_out = rd;
        will_rd = rd && (exp_q.size() > 0);
        will_wr = wr && (exp_q.size() < DEPTH);
        if (will_rd) chk({tag, ".data_o"}, 32'(data_o), 32'(exp_q[0]));
        tick();
        if (will_rd) void'(exp_q.pop_front());
        if (will_wr) exp_q.push_back(d);
        valid_in  = 1'b0;
        ready_out = 1'b0;
        chk_status(tag);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) cycle(tag, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; data_i = '0; valid_in = 1'b0; ready_out = 1'b0;
`ifdef RX_FIFO_OVF_CNT_EN
        ovf_clr = 1'b0;
`endif
        tick(); tick();
        rstn = 1'b1;
        chk_status("reset");

        // single word: visible one edge after the write, then read out
        valid_in = 1'b1; data_i = 8'hA1;
        chk("empty_wr.no_bypass", 32'(valid_out), 32'd0);
        cycle("one_wr", 1'b1, 8'hA1, 1'b0);
        chk("one_wr.data_o", 32'(data_o), 32'hA1);
        cycle("one_rd", 1'b0, '0, 1'b1);

        // fill to full, a fifth write is dropped, drain in order
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0);
        cycle("drop5", 1'b1, 8'h14, 1'b0);
        drain("drain_fill");

        // full with simultaneous write+read: only the read happens
        for (int i = 0; i < 4; i++) cycle("fill2", 1'b1, 8'(8'h20 + i), 1'b0);
        cycle("full_rw", 1'b1, 8'h24, 1'b1);
        chk("full_rw.level3", 32'(level), 32'd3);
        cycle("full_rw_next", 1'b1, 8'h24, 1'b0);
        chk("full_rw_next.level4", 32'(level), 32'd4);
        drain("drain_full_rw");

        // streaming through a single-entry occupancy across several wraps
        cycle("stream_pre", 1'b1, 8'h40, 1'b0);
        for (int i = 1; i <= 20; i++) cycle("stream", 1'b1, 8'(8'h40 + i), 1'b1);
        chk("stream.level1", 32'(level), 32'd1);
        drain("drain_stream");

        // flush with a concurrent write: everything, including that write, disappears
        for (int i = 0; i < 3; i++) cycle("pre_flush", 1'b1, 8'(8'h60 + i), 1'b0);
        flush = 1'b1; valid_in = 1'b1; data_i = 8'h6F; ready_out = 1'b1;
        tick();
        flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        exp_q.delete();
        chk_status("flush");
        cycle("post_flush", 1'b1, 8'h77, 1'b0);
        drain("drain_post_flush");

        // same again with reset mid-stream
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'(8'h80 + i), 1'b0);
        rstn = 1'b0; valid_in = 1'b1; data_i = 8'h8F;
        tick();
        rstn = 1'b1; valid_in = 1'b0;
        exp_q.delete();
        chk_status("midrst");
        cycle("post_rst", 1'b1, 8'h99, 1'b0);
        drain("drain_post_rst");

        // random mixed traffic against the model
        for (int i = 0; i < 200; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        drain("drain_rand");

`ifdef RX_FIFO_OVF_CNT_EN
        chk("ovf.init", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) cycle("ovf_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
        valid_in = 1'b1; data_i = 8'hEE;
        for (int i = 0; i < 300; i++) tick();
        valid_in = 1'b0;
        chk("ovf.sticky", 32'(ovf), 32'd1);
        chk("ovf.sat", 32'(ovf_cnt), 32'd255);
        chk_status("ovf_full");
        ovf_clr = 1'b1; valid_in = 1'b1;
        tick();
        ovf_clr = 1'b0; valid_in = 1'b0;
        chk("ovf.clr", 32'(ovf), 32'd0);
        chk("ovf_cnt.clr", 32'(ovf_cnt), 32'd0);
        drain("drain_ovf");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
